// File: rtl/audio_bar_display_if.sv
// rtl/audio_bar_display_if.sv - sample strobe, pixel coordinate and colour bundle for audio_bar_display
interface audio_bar_display_if #(
    parameter int DATA_W = 24
);
    logic                     en;
    logic                     freeze;
    logic signed [DATA_W-1:0] dataL;
    logic signed [DATA_W-1:0] dataR;
    logic [9:0]               x;
    logic [8:0]               y;
    logic [7:0]               r;
    logic [7:0]               g;
    logic [7:0]               b;

    modport master (
        output en, freeze, dataL, dataR, x, y,
        input  r, g, b
    );

    modport slave (
        input  en, freeze, dataL, dataR, x, y,
        output r, g, b
    );
endinterface

// File: rtl/audio_bar_display.sv
// rtl/audio_bar_display.sv - scrolling stereo level bars with decaying peak markers
module audio_bar_display #(
    parameter int DATA_W = 24,
    parameter int NBARS  = 16,
    parameter int BAR_W  = 40,
    parameter int Y_BASE = 479,
    parameter int DECAY  = 4
) (
    input  logic               clk,
    input  logic               rst,
    audio_bar_display_if.slave bus
);
    localparam int HN = NBARS / 2;
    localparam int CW = (DECAY > 1) ? $clog2(DECAY) : 1;

    logic [7:0]    hist_l_q [HN];
    logic [7:0]    hist_l_d [HN];
    logic [7:0]    hist_r_q [HN];
    logic [7:0]    hist_r_d [HN];
    logic [7:0]    peak_q   [NBARS];
    logic [7:0]    peak_d   [NBARS];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    r_q, g_q, b_q;
    logic [7:0]    r_d, g_d, b_d;

    logic          update;
    logic          wrap;
    logic [7:0]    h_l_new;
    logic [7:0]    h_r_new;
    logic [7:0]    nh;

    logic          hit;
    logic          left;
    logic [7:0]    hsel;
    logic [7:0]    psel;
    int            xi;
    int            yi;

    // Absolute value with the most negative code clamped, then the top 8 magnitude bits.
    function automatic logic [7:0] to_height(input logic signed [DATA_W-1:0] s);
        logic [DATA_W-1:0] mag;
        if (s[DATA_W-1]) begin
            if (s == {1'b1, {(DATA_W-1){1'b0}}})
                mag = {1'b0, {(DATA_W-1){1'b1}}};
            else
                mag = -s;
        end else begin
            mag = s;
        end
        return mag[DATA_W-2 -: 8];
    endfunction

    // History shift, decay counter and peak tracking for the next sample.
    always_comb begin
        update  = bus.en && !bus.freeze;
        h_l_new = to_height(bus.dataL);
        h_r_new = to_height(bus.dataR);
        wrap    = (cnt_q == CW'(DECAY - 1));
        nh      = 8'd0;

        hist_l_d[0] = update ? h_l_new : hist_l_q[0];
        hist_r_d[0] = update ? h_r_new : hist_r_q[0];
        for (int i = 1; i < HN; i++) begin
            hist_l_d[i] = update ? hist_l_q[i-1] : hist_l_q[i];
            hist_r_d[i] = update ? hist_r_q[i-1] : hist_r_q[i];
        end

        if (!update)
            cnt_d = cnt_q;
        else if (wrap)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);

        // A bar's new height is its post-shift history entry.
        for (int k = 0; k < NBARS; k++) begin
            nh        = (k % 2 == 0) ? hist_l_d[k/2] : hist_r_d[k/2];
            peak_d[k] = peak_q[k];
            if (update) begin
                if (nh >= peak_q[k])
                    peak_d[k] = nh;
                else if (wrap && peak_q[k] != 8'd0)
                    peak_d[k] = peak_q[k] - 8'd1;
            end
        end
    end

    // Pixel colour from the state as it stands before this edge.
    always_comb begin
        hit  = 1'b0;
        left = 1'b0;
        hsel = 8'd0;
        psel = 8'd0;
        xi   = int'(bus.x);
        yi   = int'(bus.y);
        r_d  = 8'd0;
        g_d  = 8'd0;
        b_d  = 8'd0;

        for (int k = 0; k < NBARS; k++) begin
            if (xi >= k * BAR_W && xi < (k + 1) * BAR_W) begin
                hit  = 1'b1;
                left = (k % 2 == 0);
                psel = peak_q[k];
                hsel = (k % 2 == 0) ? hist_l_q[k/2] : hist_r_q[k/2];
            end
        end

        if (hit && psel != 8'd0 && yi == Y_BASE - int'(psel)) begin
            r_d = 8'hFF;
            g_d = 8'hFF;
            b_d = 8'hFF;
        end else if (hit && hsel != 8'd0 && yi > Y_BASE - int'(hsel) && yi <= Y_BASE) begin
            r_d = left ? hsel : 8'd0;
            g_d = 8'h40;
            b_d = left ? 8'd0 : hsel;
        end
    end

    // State and output registers; reset wins over a coincident strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HN; i++) begin
                hist_l_q[i] <= 8'd0;
                hist_r_q[i] <= 8'd0;
            end
            for (int k = 0; k < NBARS; k++)
                peak_q[k] <= 8'd0;
            cnt_q <= '0;
            r_q   <= 8'd0;
            g_q   <= 8'd0;
            b_q   <= 8'd0;
        end else begin
            for (int i = 0; i < HN; i++) begin
                hist_l_q[i] <= hist_l_d[i];
                hist_r_q[i] <= hist_r_d[i];
            end
            for (int k = 0; k < NBARS; k++)
                peak_q[k] <= peak_d[k];
            cnt_q <= cnt_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
        end
    end

    assign bus.r = r_q;
    assign bus.g = g_q;
    assign bus.b = b_q;
endmodule

// File: tb/tb_audio_bar_display.sv
// tb/tb_audio_bar_display.sv - randomized self-checking bench for audio_bar_display
module tb_audio_bar_display;
    localparam int DATA_W = 24;
    localparam int NBARS  = 16;
    localparam int BAR_W  = 40;
    localparam int Y_BASE = 479;
    localparam int DECAY  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    audio_bar_display_if #(.DATA_W(DATA_W)) bus();

    audio_bar_display #(
        .DATA_W(DATA_W), .NBARS(NBARS), .BAR_W(BAR_W), .Y_BASE(Y_BASE), .DECAY(DECAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int m_l[$];
    int m_r[$];
    int m_pk[NBARS];
    int m_cnt;

    function automatic int ref_height(input logic signed [DATA_W-1:0] s);
        longint v;
        longint mx;
        mx = (longint'(1) << (DATA_W - 1)) - 1;
        v  = longint'(s);
        if (v < 0) v = -v;
        if (v > mx) v = mx;
        return int'((v >> (DATA_W - 9)) % 256);
    endfunction

    task automatic model_reset();
        m_l.delete();
        m_r.delete();
        for (int i = 0; i < NBARS / 2; i++) begin
            m_l.push_back(0);
            m_r.push_back(0);
        end
        for (int k = 0; k < NBARS; k++) m_pk[k] = 0;
        m_cnt = 0;
    endtask

    task automatic model_sample(input logic signed [DATA_W-1:0] dl, input logic signed [DATA_W-1:0] dr);
        int h;
        bit wrapped;
        m_l.push_front(ref_height(dl));
        void'(m_l.pop_back());
        m_r.push_front(ref_height(dr));
        void'(m_r.pop_back());
        m_cnt   = (m_cnt + 1) % DECAY;
        wrapped = (m_cnt == 0);
        for (int k = 0; k < NBARS; k++) begin
            h = (k % 2 == 0) ? m_l[k/2] : m_r[k/2];
            if (h >= m_pk[k]) m_pk[k] = h;
            else if (wrapped && m_pk[k] > 0) m_pk[k] = m_pk[k] - 1;
        end
    endtask

    function automatic logic [23:0] model_pix(input int xi, input int yi);
        int k;
        int h;
        int p;
        logic [7:0] h8;
        if (xi >= NBARS * BAR_W) return 24'h0;
        k  = xi / BAR_W;
        h  = (k % 2 == 0) ? m_l[k/2] : m_r[k/2];
        p  = m_pk[k];
        h8 = h[7:0];
        if (p > 0 && yi == Y_BASE - p) return 24'hFFFFFF;
        if (h > 0 && yi > Y_BASE - h && yi <= Y_BASE)
            return (k % 2 == 0) ? {h8, 8'h40, 8'h00} : {8'h00, 8'h40, h8};
        return 24'h0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic strobe(input logic fz, input logic signed [DATA_W-1:0] dl, input logic signed [DATA_W-1:0] dr);
        @(negedge clk);
        bus.en     = 1'b1;
        bus.freeze = fz;
        bus.dataL  = dl;
        bus.dataR  = dr;
        @(posedge clk);
        #1;
        bus.en     = 1'b0;
        bus.freeze = 1'b0;
        if (!fz) model_sample(dl, dr);
    endtask

    task automatic read_pix(input int xi, input int yi, output logic [23:0] v);
        @(negedge clk);
        bus.en = 1'b0;
        bus.x  = 10'(xi);
        bus.y  = 9'(yi);
        @(posedge clk);
        #1;
        v = {bus.r, bus.g, bus.b};
    endtask

    task automatic test_reset();
        logic [23:0] v;
        strobe(1'b0, 24'sh7F0000, 24'sh500000);
        @(negedge clk);
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.dataL  = 24'sh600000;
        bus.dataR  = 24'sh300000;
        bus.x      = 10'd10;
        bus.y      = 9'd400;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb got=%06h want=000000", {bus.r, bus.g, bus.b});
        end
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            read_pix(i * 130 + 10, 479 - i * 40, v);
            checks++;
            if (v !== 24'h0) begin
                errors++;
                $display("FAIL reset_pix%0d got=%06h want=000000", i, v);
            end
        end
    endtask

    task automatic test_draw();
        logic [23:0] v;
        int          px[4];
        int          py[4];
        logic [23:0] want[4];
        do_reset();
        strobe(1'b0, 24'sh400000, 24'shC00000);
        px = '{10, 50, 10, 10};
        py = '{400, 400, 351, 300};
        want = '{24'h804000, 24'h004080, 24'hFFFFFF, 24'h000000};
        for (int i = 0; i < 4; i++) begin
            read_pix(px[i], py[i], v);
            checks++;
            if (v !== want[i]) begin
                errors++;
                $display("FAIL draw_%0d x=%0d y=%0d got=%06h want=%06h", i, px[i], py[i], v, want[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] v;
        do_reset();
        strobe(1'b0, 24'sh800000, 24'sh000000);
        read_pix(10, 300, v);
        checks++;
        if (v !== 24'hFF4000) begin
            errors++;
            $display("FAIL sat_body got=%06h want=ff4000", v);
        end
        read_pix(10, 224, v);
        checks++;
        if (v !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL sat_peak got=%06h want=ffffff", v);
        end
        read_pix(639, 400, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL edge_639 got=%06h want=000000", v);
        end
        read_pix(1023, 300, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL edge_1023 got=%06h want=000000", v);
        end
    endtask

    task automatic test_shift();
        logic [23:0] v;
        do_reset();
        strobe(1'b0, 24'sh400000, 24'sh0);
        repeat (7) strobe(1'b0, 24'sh0, 24'sh0);
        read_pix(14 * BAR_W + 5, 400, v);
        checks++;
        if (v !== 24'h804000) begin
            errors++;
            $display("FAIL shift_bar14 got=%06h want=804000", v);
        end
        strobe(1'b0, 24'sh0, 24'sh0);
        read_pix(14 * BAR_W + 5, 400, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL shift_out got=%06h want=000000", v);
        end
    endtask

    task automatic test_peak_decay();
        logic [23:0] v;
        do_reset();
        strobe(1'b0, 24'sh400000, 24'sh0);
        repeat (2) strobe(1'b0, 24'sh0, 24'sh0);
        read_pix(10, 351, v);
        checks++;
        if (v !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL decay_hold got=%06h want=ffffff", v);
        end
        strobe(1'b0, 24'sh0, 24'sh0);
        read_pix(10, 352, v);
        checks++;
        if (v !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL decay_step got=%06h want=ffffff", v);
        end
        read_pix(10, 351, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL decay_old got=%06h want=000000", v);
        end
    endtask

    task automatic test_freeze();
        logic [23:0] v;
        repeat (5) strobe(1'b1, 24'sh7FFFFF, 24'sh123456);
        read_pix(10, 352, v);
        checks++;
        if (v !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL freeze_peak got=%06h want=ffffff", v);
        end
        read_pix(10, 470, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL freeze_hist got=%06h want=000000", v);
        end
        for (int i = 0; i < 130 * DECAY; i++) strobe(1'b0, 24'sh0, 24'sh0);
        read_pix(10, 479, v);
        checks++;
        if (v !== 24'h0) begin
            errors++;
            $display("FAIL floor_pix got=%06h want=000000", v);
        end
        for (int k = 0; k < NBARS; k++) begin
            read_pix(k * BAR_W + 3, 479, v);
            checks++;
            if (v !== model_pix(k * BAR_W + 3, 479) || v !== 24'h0) begin
                errors++;
                $display("FAIL floor_bar%0d got=%06h want=000000", k, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] want;
        logic [23:0] got;
        logic signed [DATA_W-1:0] dl;
        logic signed [DATA_W-1:0] dr;
        logic e;
        logic fz;
        int xi;
        int yi;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 2) != 0);
            fz = ($urandom_range(0, 5) == 0);
            dl = ($urandom_range(0, 15) == 0) ? 24'sh800000 : DATA_W'($urandom);
            dr = ($urandom_range(0, 15) == 0) ? 24'sh800000 : DATA_W'($urandom);
            xi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
            yi = ($urandom_range(0, 1) == 0) ? int'($urandom_range(200, 479)) : int'($urandom_range(0, 511));
            @(negedge clk);
            bus.en     = e;
            bus.freeze = fz;
            bus.dataL  = dl;
            bus.dataR  = dr;
            bus.x      = 10'(xi);
            bus.y      = 9'(yi);
            want = model_pix(xi, yi);
            @(posedge clk);
            #1;
            got = {bus.r, bus.g, bus.b};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rand_%0d x=%0d y=%0d got=%06h want=%06h", i, xi, yi, got, want);
            end
            if (e && !fz) model_sample(dl, dr);
        end
        bus.en     = 1'b0;
        bus.freeze = 1'b0;
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.freeze = 1'b0;
        bus.dataL  = '0;
        bus.dataR  = '0;
        bus.x      = '0;
        bus.y      = '0;
        model_reset();
        do_reset();
        test_reset();
        test_draw();
        test_saturation();
        test_shift();
        test_peak_decay();
        test_freeze();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
